// File: rtl/cla_word_sequencer_if.sv
// rtl/cla_word_sequencer_if.sv - operand/result handshake bundle for cla_word_sequencer (Sub present with CLA_SEQ_SUB_EN)
interface cla_word_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
);
  localparam int N = WIDTH * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
`ifdef CLA_SEQ_SUB_EN
  logic         Sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Sum;
  logic         Cout;

  // Producer/consumer side: offers operands, accepts results.
  modport master (
    output in_valid, A, B, Cin,
`ifdef CLA_SEQ_SUB_EN
    output Sub,
`endif
    output out_ready,
    input  in_ready, out_valid, Sum, Cout
  );

  // Sequencer side.
  modport slave (
    input  in_valid, A, B, Cin,
`ifdef CLA_SEQ_SUB_EN
    input  Sub,
`endif
    input  out_ready,
    output in_ready, out_valid, Sum, Cout
  );
endinterface

// File: rtl/cla_word_sequencer.sv
// rtl/cla_word_sequencer.sv - word-serial carry-lookahead adder, one WIDTH-bit word per cycle; CLA_SEQ_SUB_EN adds subtract
module cla_word_sequencer #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_word_sequencer_if.slave   bus
);
  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [WIDTH-1:0] wa, wb, wg, wp, wsum;
  logic [WIDTH:0]   wc;
  logic             term, cl;

  // One WIDTH-bit lookahead stage on the selected word: every carry is a flat
  // sum of generate terms gated by the propagates above them.
  always_comb begin
    wa   = a_q[idx_q*WIDTH +: WIDTH];
    wb   = b_q[idx_q*WIDTH +: WIDTH];
    wg   = wa & wb;
    wp   = wa ^ wb;
    wc   = '0;
    term = 1'b0;
    cl   = 1'b0;
    wc[0] = carry_q;
    for (int i = 0; i < WIDTH; i++) begin
      term = carry_q;
      for (int k = 0; k <= i; k++) term = term & wp[k];
      cl = term;
      for (int j = 0; j <= i; j++) begin
        term = wg[j];
        for (int k = j + 1; k <= i; k++) term = term & wp[k];
        cl = cl | term;
      end
      wc[i+1] = cl;
    end
    wsum = wp ^ wc[WIDTH-1:0];
  end

  // Next-state: capture in IDLE, one word per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
`ifdef CLA_SEQ_SUB_EN
          b_d     = bus.Sub ? ~bus.B : bus.B;
          carry_d = bus.Sub ? 1'b1 : bus.Cin;
`else
          b_d     = bus.B;
          carry_d = bus.Cin;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*WIDTH +: WIDTH] = wsum;
        carry_d = wc[WIDTH];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST) begin
          cout_d  = wc[WIDTH];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
endmodule

// File: doc/cla_word_sequencer.md
CLA_WORD_SEQUENCER -- requirements
Module: cla_word_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, is the bit width of one adder word processed per cycle.
REQ-002 Parameter WORDS, default 4, is the number of words per operand (WORDS >= 2); total operand width N = WIDTH*WORDS.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 A, B  input  N each  operands.
REQ-008 Cin  input  1  carry into word 0.
REQ-009 Sub  input  1  subtract request; present only when SUB_EN is defined.
REQ-010 out_valid  output  1  result held on Sum/Cout.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 Sum  output  N  result.
REQ-013 Cout  output  1  carry out of the top word.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE with in_valid=1 SHALL capture A, B and Cin (and Sub) on the edge, clear the word index to 0, load the carry register with Cin and enter RUN; in_valid=0 SHALL keep the block in IDLE.
REQ-017 Each RUN cycle SHALL add word[idx] of the captured A and B plus the carry register through one WIDTH-bit generate/propagate carry-lookahead stage, write the result into Sum word[idx], load the stage carry-out into the carry register and increment idx.
REQ-018 The RUN cycle with idx = WORDS-1 SHALL enter DONE and load Cout with the final carry.
REQ-019 Latency SHALL be exactly WORDS cycles: an accept on edge k SHALL give out_valid=1 after edge k+WORDS.
REQ-020 DONE SHALL hold Sum, Cout and out_valid stable until out_ready=1, then return to IDLE on that edge.
REQ-021 Minimum issue interval SHALL be WORDS+2 cycles, with no overlap of operations.
REQ-022 in_valid and operand changes outside IDLE SHALL be ignored; captured operands SHALL NOT change during RUN.
REQ-023 The result SHALL equal (A + B + Cin) mod 2^N, and Cout SHALL be bit N of the full sum.
REQ-024 Sum word bits SHALL not be read as meaningful while out_valid=0; upper words keep their previous values until overwritten.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, idx=0, carry=0, Sum=0, Cout=0, out_valid=0 and clear the captured operands, so in_ready=1 while in reset.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no result delivered; the first operation after release SHALL be unaffected.
REQ-027 Reset release SHALL take effect on the first clk edge with rst_n=1.

Configuration
REQ-028 Macro CLA_SEQ_SUB_EN, when defined, SHALL add the Sub port; Sub=1 at accept SHALL capture ~B and force carry-in 1, so the result is A - B (Cin ignored) and Cout=1 means no borrow.
REQ-029 Without CLA_SEQ_SUB_EN, the Sub port SHALL be absent and the block SHALL perform addition only, identical to the REQ-016 to REQ-023 behaviour.

Verification (WIDTH=4, WORDS=4)
REQ-030 Stimulus: A=0xFFFF, B=0x0001, Cin=0, out_ready=1 -> required response: out_valid rises exactly 4 cycles after accept with Sum=0x0000, Cout=1, then IDLE and in_ready=1 on the next edge.
REQ-031 Stimulus: A=0x1234, B=0x4321, Cin=1, then out_ready held 0 for 5 cycles -> required response: Sum=0x5556 and Cout=0 held constant, out_valid=1 throughout, return to IDLE on the edge out_ready goes 1.
REQ-032 Stimulus: accept A=0x00F0, B=0x0010, then drive A=0xFFFF, B=0xFFFF with in_valid=1 during RUN -> required response: Sum=0x0100, in_ready=0 during RUN and DONE, second set accepted only after return to IDLE.
REQ-033 Stimulus: pulse rst_n low during RUN at idx=2 -> required response: out_valid=0, in_ready=1 and Sum=0 immediately without a clock edge; next op 0x0001+0x0001 gives Sum=0x0002.
REQ-034 Stimulus (CLA_SEQ_SUB_EN defined): Sub=1, A=0x0005, B=0x0007 -> required response: Sum=0xFFFE, Cout=0; with A=0x0007, B=0x0005 -> Sum=0x0002, Cout=1.
REQ-035 Stimulus: 1000 random operand sets with random in_valid/out_ready stalls -> required response: every result matches A+B+Cin to 17 bits and no result is lost or duplicated.
